vid_fetch: RTL

//  Memory-side responder for the 640x480 16bpp display controller's read port.

---
 rtl/vid_fetch.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/vid_fetch.sv
// ---------------------------------------------------------------------------
// vid_fetch -- framebuffer prefetcher for the display controller read port.
//
// Fetches the frame sequentially from SDRAM in BURST-word bursts into a
// DEPTH-word FIFO. The display controller pops one 32-bit word per vid_req.
// A rising edge on vsync restarts the frame from BASE_ADDR.
//
// Optional build macro: VID_FETCH_STATS_EN adds the underflow_cnt output.
// This output holds the previous frame's count of underflow pops.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   ce                clock enable; state is frozen while low
//   vsync             display vsync; rising edge = frame start
//   vid_req           pop one word from the FIFO
//   viddata[31:0]     FIFO head word (registered)
//   mem_rd_req        burst request to the SDRAM arbiter, held until mem_ack
//   mem_addr[AW-1:0]  burst start word address
//   mem_ack           arbiter accepted the burst request
//   mem_rd_valid      one returned burst word on mem_rd_data
//   mem_rd_data[31:0] returned burst data
//   underflow         sticky flag: pop while empty; cleared at frame start
//   underflow_cnt     (VID_FETCH_STATS_EN only) previous frame's underflow pops
// ---------------------------------------------------------------------------
module vid_fetch #(
    parameter int              DEPTH       = 16,
    parameter int              BURST       = 8,
    parameter int              AW          = 24,
    parameter logic [AW-1:0]   BASE_ADDR   = '0,
    parameter int              FRAME_WORDS = 153600
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ce,
    input  logic          vsync,
    input  logic          vid_req,
    output logic [31:0]   viddata,
    output logic          mem_rd_req,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_ack,
    input  logic          mem_rd_valid,
    input  logic [31:0]   mem_rd_data,
`ifdef VID_FETCH_STATS_EN
    output logic [15:0]   underflow_cnt,
`endif
    output logic          underflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int IW = $clog2(BURST) + 1;
    localparam int FW = $clog2(FRAME_WORDS + 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DATA, S_FLUSH} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [IW-1:0]   inflight_q, inflight_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [FW-1:0]   fetched_q, fetched_d;
    logic            vsync_q, vsync_d;
    logic            underflow_q, underflow_d;
    logic            mem_rd_req_q, mem_rd_req_d;
    logic [31:0]     viddata_q, viddata_d;
    logic [31:0]     mem_q [DEPTH];

    logic            frame_start, push, pop, ul_pop, ret_word;
    logic [31:0]     free_words;

`ifdef VID_FETCH_STATS_EN
    logic [15:0]     ul_live_q, ul_live_d;
    logic [15:0]     ul_hold_q, ul_hold_d;
`endif

    always_comb begin
        frame_start = ce & vsync & ~vsync_q;
        // Only words of a live burst enter the FIFO; flushed words are dropped.
        push        = ce & mem_rd_valid & (state_q == S_DATA) & ~frame_start;
        pop         = ce & vid_req & (count_q != '0) & ~frame_start;
        ul_pop      = ce & vid_req & (count_q == '0) & ~frame_start;
        // Any returned word, kept or discarded, retires one in-flight credit.
        ret_word    = ce & mem_rd_valid & ((state_q == S_DATA) | (state_q == S_FLUSH));
        // Free space net of words already promised by an outstanding burst.
        free_words  = 32'(DEPTH) - 32'(count_q) - 32'(inflight_q);

        state_d      = state_q;
        count_d      = count_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        inflight_d   = inflight_q;
        addr_d       = addr_q;
        fetched_d    = fetched_q;
        vsync_d      = vsync_q;
        underflow_d  = underflow_q;
        mem_rd_req_d = mem_rd_req_q;
        viddata_d    = viddata_q;
`ifdef VID_FETCH_STATS_EN
        ul_live_d    = ul_live_q;
        ul_hold_d    = ul_hold_q;
`endif

        if (ce) begin
            vsync_d = vsync;
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
            if (ul_pop)   underflow_d = 1'b1;
            if (ret_word) inflight_d  = inflight_q - IW'(1);

            unique case (state_q)
                S_IDLE: begin
                    if (!frame_start && free_words >= 32'(BURST) &&
                        fetched_q < FW'(FRAME_WORDS))
                        state_d = S_REQ;
                end
                S_REQ: begin
                    if (mem_ack) begin
                        addr_d     = addr_q + AW'(BURST);
                        fetched_d  = fetched_q + FW'(BURST);
                        inflight_d = IW'(BURST);
                        state_d    = frame_start ? S_FLUSH : S_DATA;
                    end else if (frame_start) begin
                        state_d = S_IDLE;
                    end
                end
                S_DATA: begin
                    if (inflight_d == '0)  state_d = S_IDLE;
                    else if (frame_start)  state_d = S_FLUSH;
                end
                S_FLUSH: begin
                    if (inflight_d == '0)  state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase

`ifdef VID_FETCH_STATS_EN
            if (ul_pop && ul_live_q != 16'hFFFF) ul_live_d = ul_live_q + 16'd1;
`endif

            if (frame_start) begin
                count_d     = '0;
                wr_ptr_d    = '0;
                rd_ptr_d    = '0;
                addr_d      = BASE_ADDR;
                fetched_d   = '0;
                underflow_d = 1'b0;
`ifdef VID_FETCH_STATS_EN
                ul_hold_d   = ul_live_q;
                ul_live_d   = '0;
`endif
            end

            mem_rd_req_d = (state_d == S_REQ);

            // Preload the next head word. Bypass the array when the word being
            // written this cycle becomes the head. When empty, hold the last value.
            if (count_d != '0)
                viddata_d = (push && wr_ptr_q == rd_ptr_d) ? mem_rd_data : mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            count_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            inflight_q   <= '0;
            addr_q       <= BASE_ADDR;
            fetched_q    <= '0;
            vsync_q      <= 1'b0;
            underflow_q  <= 1'b0;
            mem_rd_req_q <= 1'b0;
            viddata_q    <= '0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            inflight_q   <= inflight_d;
            addr_q       <= addr_d;
            fetched_q    <= fetched_d;
            vsync_q      <= vsync_d;
            underflow_q  <= underflow_d;
            mem_rd_req_q <= mem_rd_req_d;
            viddata_q    <= viddata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= mem_rd_data;
    end

`ifdef VID_FETCH_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ul_live_q <= '0;
            ul_hold_q <= '0;
        end else begin
            ul_live_q <= ul_live_d;
            ul_hold_q <= ul_hold_d;
        end
    end

    assign underflow_cnt = ul_hold_q;
`endif

    assign viddata    = viddata_q;
    assign mem_rd_req = mem_rd_req_q;
    assign mem_addr   = addr_q;
    assign underflow  = underflow_q;

endmodule
